// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: FSM states,
// instruction encodings and ALU operations.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// Unified instruction/data memory port of the multicycle core.
interface mc_if #(parameter int N = 32);
    // mem_req acts as valid: mem_we, mem_addr and mem_wdata are held stable from
    // the cycle mem_req rises until a rising edge that sees mem_ready=1, which
    // completes the transfer; mem_rdata is consumed in that same cycle.
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mc_ctrl.sv
// Control FSM and instruction decode; state is exported so the datapath
// (and any bound checker) can key off it directly.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic    mem_ready,
    output state_t  state,
    output alu_op_t alu_op,
    output logic    mem_req,
    output logic    mem_we,
    output logic    halted
);

    state_t state_next;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_BEQ:       state_next = BRANCH;
                    OP_J, OP_JAL: state_next = JUMP;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_next = EXEC;
                            FN_JR:   state_next = JUMP;
                            default: state_next = HALT;
                        endcase
                    end
                    default:      state_next = HALT;
                endcase
            end
            MEMADR: state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWR:  if (mem_ready) state_next = FETCH;
            EXEC:   state_next = ALUWB;
            ADDIEX: state_next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_next = FETCH;
            HALT:   state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Requests are masked during reset so an in-flight access is dropped at once.
    always_comb begin
        mem_req = !reset && (state == FETCH || state == MEMRD || state == MEMWR);
        mem_we  = (state == MEMWR);
        halted  = (state == HALT);
        alu_op  = (state == EXEC) ? funct_to_alu(funct) : ALU_ADD;
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core: PC, IR, A/B/ALUOut/MDR, ALU and register file
// around the mc_ctrl FSM, sharing one memory port for fetch and data.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    mc_if.master         mem,
    output logic [N-1:0] pc,
    output logic         halted
);

    state_t       state;
    alu_op_t      alu_op;
    logic [31:0]  ir;
    logic [N-1:0] a, b, aluout, mdr;
    logic [N-1:0] rf [32];
    logic [N-1:0] alu_a, alu_b, alu_y, sext, jump_target, rf_rs, rf_rt;
    logic         rf_we;
    logic [4:0]   rf_wa;
    logic [N-1:0] rf_wd;

    wire [5:0]  opcode = ir[31:26];
    wire [4:0]  rs     = ir[25:21];
    wire [4:0]  rt     = ir[20:16];
    wire [4:0]  rd     = ir[15:11];

    mc_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (ir[5:0]),
        .mem_ready (mem.mem_ready),
        .state     (state),
        .alu_op    (alu_op),
        .mem_req   (mem.mem_req),
        .mem_we    (mem.mem_we),
        .halted    (halted)
    );

    assign sext        = {{(N-16){ir[15]}}, ir[15:0]};
    assign jump_target = {pc[N-1:28], ir[25:0], 2'b00};
    assign rf_rs       = (rs == 5'd0) ? '0 : rf[rs];
    assign rf_rt       = (rt == 5'd0) ? '0 : rf[rt];

    assign mem.mem_addr  = (state == MEMRD || state == MEMWR) ? aluout : pc;
    assign mem.mem_wdata = b;

    // DECODE reuses the ALU for the speculative branch target (pc already +4).
    always_comb begin
        alu_a = a;
        alu_b = sext;
        case (state)
            DECODE:  begin alu_a = pc; alu_b = sext << 2; end
            EXEC:    alu_b = b;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {{(N-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = aluout;
        case (state)
            MEMWB:  begin rf_we = 1'b1; rf_wd = mdr; end
            ALUWB:  begin rf_we = 1'b1; rf_wa = rd; end
            ADDIWB: rf_we = 1'b1;
            JUMP:   begin rf_we = (opcode == OP_JAL); rf_wa = 5'd31; rf_wd = pc; end
            default: ;
        endcase
    end

    // Register file is deliberately not reset; r0 is never written.
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rf_wa != 5'd0) rf[rf_wa] <= rf_wd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            case (state)
                FETCH: if (mem.mem_ready) begin
                    ir <= mem.mem_rdata[31:0];
                    pc <= pc + N'(4);
                end
                DECODE: begin
                    a      <= rf_rs;
                    b      <= rf_rt;
                    aluout <= alu_y;
                end
                MEMADR, EXEC, ADDIEX: aluout <= alu_y;
                MEMRD:  if (mem.mem_ready) mdr <= mem.mem_rdata;
                BRANCH: if (a == b) pc <= aluout;
                JUMP:   pc <= (opcode == OP_RTYPE) ? a : jump_target;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: small programs in a bench-owned memory,
// fetch/write/stall logs compared against hand-computed cycle-stamped traces.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        halted;
    int          cyc;
    int          n_tests;
    int          n_fail;

    logic [31:0] mem_arr [512];
    logic [63:0] fetch_q [$];
    logic [63:0] write_q [$];
    logic [31:0] wdata_q [$];
    logic [63:0] stall_q [$];
    logic [63:0] exp_q   [$];

    mc_if #(.N(32)) bus ();

    mc_datapath #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem    (bus),
        .pc     (pc),
        .halted (halted)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model / monitor ----------------
    assign bus.mem_rdata = mem_arr[bus.mem_addr[10:2]];

    always @(negedge clk) begin
        if (!reset && bus.mem_req) begin
            if (!bus.mem_ready)
                stall_q.push_back({31'd0, bus.mem_we, bus.mem_addr});
            else if (bus.mem_we) begin
                write_q.push_back({32'(cyc), bus.mem_addr});
                wdata_q.push_back(bus.mem_wdata);
            end else if (bus.mem_addr == pc)
                fetch_q.push_back({32'(cyc), bus.mem_addr});
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic fill_halt();
        for (int i = 0; i < 512; i++) mem_arr[i] = 32'hFC00_0000;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        fetch_q.delete();
        write_q.delete();
        wdata_q.delete();
        stall_q.delete();
        reset = 1'b0;
    endtask

    task automatic exp_fetch(input int c, input logic [31:0] addr);
        exp_q.push_back({32'(c), addr});
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_fetches(input string tag);
        logic [63:0] got;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < fetch_q.size()) ? fetch_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
            check_eq($sformatf("%s_fetch%0d", tag, i), got, exp_q[i]);
        end
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.mem_ready = 1'b1;

        // Program A: ALU ops, sw/lw with stall, beq not taken, jal/jr, then illegal opcode.
        fill_halt();
        mem_arr[0]   = enc_i(6'h08, 0, 1, 16'd5);       // addi $1,$0,5
        mem_arr[1]   = enc_i(6'h08, 0, 2, 16'd7);       // addi $2,$0,7
        mem_arr[2]   = enc_r(1, 2, 3, 6'h20);           // add  $3,$1,$2
        mem_arr[3]   = enc_i(6'h2B, 0, 3, 16'h0040);    // sw   $3,0x40($0)
        mem_arr[4]   = enc_i(6'h04, 1, 2, 16'hFFFF);    // beq  $1,$2,-1 (not taken)
        mem_arr[5]   = enc_i(6'h23, 0, 4, 16'h0040);    // lw   $4,0x40($0)
        mem_arr[6]   = enc_r(1, 2, 5, 6'h22);           // sub  $5,$1,$2
        mem_arr[7]   = enc_r(5, 1, 6, 6'h2A);           // slt  $6,$5,$1
        mem_arr[8]   = {6'h03, 26'h100};                // jal  0x100
        mem_arr[9]   = enc_r(2, 3, 7, 6'h24);           // and  $7,$2,$3
        mem_arr[10]  = enc_r(2, 3, 8, 6'h25);           // or   $8,$2,$3
        mem_arr[11]  = enc_r(1, 5, 9, 6'h2A);           // slt  $9,$1,$5
        mem_arr[12]  = enc_i(6'h08, 0, 0, 16'd5);       // addi $0,$0,5
        mem_arr[13]  = enc_i(6'h2B, 0, 0, 16'h0044);    // sw   $0,0x44($0)
        mem_arr[14]  = 32'hFC00_0000;                   // opcode 3F
        mem_arr[16]  = 32'd12;                          // data word at 0x40
        mem_arr[256] = enc_r(31, 0, 0, 6'h08);          // jr   $31 at 0x400

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("req_in_reset", {63'd0, bus.mem_req}, 64'd0);
        release_reset();

        wait_cyc(22);
        bus.mem_ready = 1'b0;
        wait_cyc(25);
        bus.mem_ready = 1'b1;
        wait_cyc(28);
        check_eq("lw_rf4", {32'd0, dut.rf[4]}, 64'd12);

        wait_cyc(80);
        exp_fetch(0,  32'h00); exp_fetch(4,  32'h04); exp_fetch(8,  32'h08);
        exp_fetch(12, 32'h0C); exp_fetch(16, 32'h10); exp_fetch(19, 32'h14);
        exp_fetch(27, 32'h18); exp_fetch(31, 32'h1C); exp_fetch(35, 32'h20);
        exp_fetch(38, 32'h400); exp_fetch(41, 32'h24); exp_fetch(45, 32'h28);
        exp_fetch(49, 32'h2C); exp_fetch(53, 32'h30); exp_fetch(57, 32'h34);
        exp_fetch(61, 32'h38);
        check_fetches("progA");
        check_eq("progA_fetch_count", 64'(fetch_q.size()), 64'd16);

        check_eq("write_count", 64'(write_q.size()), 64'd2);
        check_eq("write0_cyc_addr", (write_q.size() > 0) ? write_q[0] : '1, {32'd15, 32'h40});
        check_eq("write0_data", (wdata_q.size() > 0) ? {32'd0, wdata_q[0]} : '1, 64'd12);
        check_eq("write1_cyc_addr", (write_q.size() > 1) ? write_q[1] : '1, {32'd60, 32'h44});
        check_eq("write1_data_r0", (wdata_q.size() > 1) ? {32'd0, wdata_q[1]} : '1, 64'd0);

        check_eq("stall_count", 64'(stall_q.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("lw_stall_addr%0d", i),
                     (i < stall_q.size()) ? stall_q[i] : '1, 64'h40);

        check_eq("rf1", {32'd0, dut.rf[1]},  64'd5);
        check_eq("rf2", {32'd0, dut.rf[2]},  64'd7);
        check_eq("rf3_add", {32'd0, dut.rf[3]}, 64'd12);
        check_eq("rf5_sub", {32'd0, dut.rf[5]}, 64'hFFFF_FFFE);
        check_eq("rf6_slt_true", {32'd0, dut.rf[6]}, 64'd1);
        check_eq("rf7_and", {32'd0, dut.rf[7]}, 64'd4);
        check_eq("rf8_or", {32'd0, dut.rf[8]}, 64'd15);
        check_eq("rf9_slt_signed", {32'd0, dut.rf[9]}, 64'd0);
        check_eq("rf31_jal_link", {32'd0, dut.rf[31]}, 64'h24);

        check_eq("halted_set", {63'd0, halted}, 64'd1);
        check_eq("halt_pc", {32'd0, pc}, 64'h3C);
        @(negedge clk);
        check_eq("halt_no_req", {63'd0, bus.mem_req}, 64'd0);

        // Reset out of HALT, then program B: taken branches.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_pc", {32'd0, pc}, 64'd0);
        check_eq("reset_halted", {63'd0, halted}, 64'd0);
        @(negedge clk);
        check_eq("req_in_reset2", {63'd0, bus.mem_req}, 64'd0);
        fill_halt();
        mem_arr[0] = enc_i(6'h04, 0, 0, 16'd3);         // beq $0,$0,3 -> 0x10
        mem_arr[4] = enc_i(6'h04, 1, 1, 16'hFFFF);      // beq $1,$1,-1 at 0x10
        release_reset();
        wait_cyc(11);
        exp_fetch(0, 32'h00); exp_fetch(3, 32'h10);
        exp_fetch(6, 32'h10); exp_fetch(9, 32'h10);
        check_fetches("progB");

        // Program C: reset lands during a stalled store.
        reset = 1'b1;
        fill_halt();
        mem_arr[0] = enc_i(6'h2B, 0, 3, 16'h0048);      // sw $3,0x48($0)
        release_reset();
        wait_cyc(3);
        bus.mem_ready = 1'b0;
        wait_cyc(5);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        check_eq("memwr_stall_count", 64'(stall_q.size()), 64'd2);
        for (int i = 0; i < 2; i++)
            check_eq($sformatf("memwr_stall%0d", i),
                     (i < stall_q.size()) ? stall_q[i] : '1, {31'd0, 1'b1, 32'h48});
        @(negedge clk);
        check_eq("req_reset_over_ready", {63'd0, bus.mem_req}, 64'd0);
        @(posedge clk);
        #1;
        check_eq("aborted_write", 64'(write_q.size()), 64'd0);
        check_eq("abort_pc", {32'd0, pc}, 64'd0);
        release_reset();
        wait_cyc(2);
        exp_fetch(0, 32'h00);
        check_fetches("progC");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter N, default 32, giving the datapath/register/address width (N >= 32).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000 zero-extended to N bits, giving the PC value loaded by reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req, output, 1 bit: memory access request.
REQ-006 SHALL have port mem_we, output, 1 bit: the request is a write; valid only while mem_req=1.
REQ-007 SHALL have port mem_addr, output, N bits: byte address of the request.
REQ-008 SHALL have port mem_wdata, output, N bits: store data.
REQ-009 SHALL have port mem_rdata, input, N bits: read data; valid in the cycle mem_ready=1.
REQ-010 SHALL have port mem_ready, input, 1 bit: completes the current request.
REQ-011 SHALL have port pc, output, N bits: the current program counter.
REQ-012 SHALL have port halted, output, 1 bit: sticky illegal-instruction indication.

Function
REQ-013 SHALL run one unified-memory multicycle MIPS subset: R-type add/sub/and/or/slt/jr, and lw, sw, addi, beq, j, jal.
REQ-014 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP and HALT.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ready it SHALL latch IR and set pc<=pc+4, then go to DECODE; it SHALL hold while mem_ready=0.
REQ-016 DECODE: SHALL latch A=rf[rs] and B=rf[rt], and compute the branch target pc+(signext(imm)<<2) into ALUOut.
REQ-017 DECODE dispatch: lw/sw to MEMADR; R-type (except jr) to EXEC; addi to ADDIEX; beq to BRANCH; j/jal/jr to JUMP; any other opcode or funct to HALT.
REQ-018 MEMADR: ALUOut<=A+signext(imm); next state is MEMRD for lw and MEMWR for sw.
REQ-019 MEMRD: SHALL request a read at ALUOut; on mem_ready it latches MDR and goes to MEMWB.
REQ-020 MEMWR: SHALL request a write at ALUOut with mem_wdata=B; on mem_ready it goes to FETCH.
REQ-021 MEMWB: SHALL write rf[rt]<=MDR, then go to FETCH.
REQ-022 EXEC: ALUOut<=A op B; then ALUWB writes rf[rd] and goes to FETCH.
REQ-023 ADDIEX/ADDIWB: ALUOut<=A+signext(imm), then rf[rt]<=ALUOut, then FETCH.
REQ-024 BRANCH: if A==B then pc<=ALUOut; SHALL go to FETCH in either case.
REQ-025 JUMP target selection: j sets pc<={pc[N-1:28], addr26, 2'b00}; jal does the same and also writes rf[31]<=pc (already pc+4); jr sets pc<=A; all go to FETCH.
REQ-026 Register writes to register 0 SHALL be discarded; reads of register 0 SHALL return 0.
REQ-027 Arithmetic SHALL be modulo 2^N with no overflow trap; slt SHALL be a signed comparison producing 1 or 0.
REQ-028 Latency with mem_ready tied high SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq, j, jal and jr 3 cycles; each wait cycle adds 1.
REQ-029 mem_req SHALL be asserted only in FETCH, MEMRD and MEMWR; mem_addr and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-030 HALT SHALL hold mem_req=0 and halted=1, and SHALL leave HALT only on reset.

Reset
REQ-031 While reset=1 at a clock edge: state<=FETCH, pc<=RESET_PC, halted<=0, and IR, A, B, ALUOut and MDR <= 0.
REQ-032 While reset=1, mem_req SHALL be 0; the first request SHALL be issued in the cycle after reset deasserts.
REQ-033 Reset SHALL take priority over mem_ready in any state, aborting a pending access with no register or pc side effect.
REQ-034 Register-file contents other than register 0 are not reset.

Structure
REQ-035 A shared package mc_pkg SHALL hold the state enum, opcode/funct constants and the ALU-op enum.
REQ-036 There SHALL be one sub-module, mc_ctrl (the FSM plus decode); the datapath registers, ALU and register file stay in mc_datapath.

Verification
REQ-037 Scenario 1: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0) -> write at address 0x40 with data 12; cycle count 4+4+4+4.
REQ-038 Scenario 2: lw $4,0x40($0) with mem_ready low for 3 cycles in MEMRD -> rf[4]=12 after 8 cycles; mem_addr stays 0x40 throughout the wait.
REQ-039 Scenario 3: beq $1,$1,-1 at pc 0x10 -> the next fetch address is 0x10; beq $1,$2,-1 -> the next fetch address is 0x14.
REQ-040 Scenario 4: jal 0x100 at pc 0x20 -> rf[31]=0x24 and the next fetch is at 0x400; then jr $31 -> the next fetch is at 0x24.
REQ-041 Scenario 5: opcode 6'h3F -> halted=1 and mem_req=0 indefinitely; after reset, pc=RESET_PC and halted=0.
REQ-042 Scenario 6: reset asserted during MEMWR with mem_ready=0 -> no write is observed, and the next request is a fetch at RESET_PC.
